// File: rtl/pcie_link_mon.sv
// rtl/pcie_link_mon.sv - PCIe link monitor: debounced link-up, drop counter, retrain pulse, link LED
module pcie_link_mon #(
    parameter logic [4:0]  L0_CODE       = 5'h0F,
    parameter int          DEBOUNCE_CYC  = 1024,
    parameter logic [23:0] TRAIN_TIMEOUT = 24'd10_000_000,
    parameter int          LED_BIT       = 21
) (
    input  logic       core_clk,
    input  logic       core_rst,
    input  logic       ltssm_enable_i,
    input  logic [4:0] ltssm_state_i,
    input  logic       dl_link_up_i,
    output logic       link_up_o,
    output logic [7:0] link_down_cnt_o,
    output logic       retrain_req_o,
    output logic       link_led_o,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        TRAIN  = 2'b01,
        STABLE = 2'b10,
        UP     = 2'b11
    } state_t;

    localparam logic [23:0] DEB_LAST   = 24'(DEBOUNCE_CYC - 1);
    localparam logic [23:0] TRAIN_LAST = TRAIN_TIMEOUT - 24'd1;

    state_t      state_q, state_d;
    logic [23:0] phase_q, phase_d;
    logic [23:0] led_cnt_q, led_cnt_d;
    logic        link_up_q, link_up_d;
    logic [7:0]  down_cnt_q, down_cnt_d;
    logic        retrain_q, retrain_d;
    logic        led_q, led_d;
    logic        ok;

    assign ok = dl_link_up_i && (ltssm_state_i == L0_CODE);

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            led_cnt_q  <= '0;
            link_up_q  <= 1'b0;
            down_cnt_q <= '0;
            retrain_q  <= 1'b0;
            led_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            led_cnt_q  <= led_cnt_d;
            link_up_q  <= link_up_d;
            down_cnt_q <= down_cnt_d;
            retrain_q  <= retrain_d;
            led_q      <= led_d;
        end
    end

    // Phase counter is shared: it times the training timeout and the debounce window.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        if (!ltssm_enable_i) begin
            state_d = IDLE;
            phase_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = TRAIN;
                    phase_d = '0;
                end
                TRAIN: begin
                    if (ok) begin
                        state_d = STABLE;
                        phase_d = '0;
                    end else if (phase_q == TRAIN_LAST) begin
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 24'd1;
                    end
                end
                STABLE: begin
                    if (!ok) begin
                        state_d = TRAIN;
                        phase_d = '0;
                    end else if (phase_q == DEB_LAST) begin
                        state_d = UP;
                        phase_d = '0;
                    end else begin
                        phase_d = phase_q + 24'd1;
                    end
                end
                UP: begin
                    if (!ok) begin
                        state_d = TRAIN;
                        phase_d = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    phase_d = '0;
                end
            endcase
        end
    end

    always_comb begin
        led_cnt_d  = led_cnt_q + 24'd1;
        link_up_d  = (state_d == UP);
        retrain_d  = ltssm_enable_i && (state_q == TRAIN) && !ok && (phase_q == TRAIN_LAST);
        down_cnt_d = down_cnt_q;
        if (ltssm_enable_i && (state_q == UP) && !ok && (down_cnt_q != 8'hFF)) begin
            down_cnt_d = down_cnt_q + 8'd1;
        end
        case (state_d)
            IDLE:    led_d = 1'b0;
            UP:      led_d = 1'b1;
            default: led_d = led_cnt_d[LED_BIT];
        endcase
    end

    assign link_up_o       = link_up_q;
    assign link_down_cnt_o = down_cnt_q;
    assign retrain_req_o   = retrain_q;
    assign link_led_o      = led_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_pcie_link_mon.sv
// tb/tb_pcie_link_mon.sv - directed scoreboard bench for pcie_link_mon
module tb_pcie_link_mon;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [4:0] ltssm;
    logic       dl_up;
    logic       link_up;
    logic [7:0] down_cnt;
    logic       retrain;
    logic       led;
    logic [1:0] state;

    pcie_link_mon #(
        .L0_CODE      (5'h0F),
        .DEBOUNCE_CYC (8),
        .TRAIN_TIMEOUT(24'd32),
        .LED_BIT      (2)
    ) dut (
        .core_clk       (clk),
        .core_rst       (rst),
        .ltssm_enable_i (en),
        .ltssm_state_i  (ltssm),
        .dl_link_up_i   (dl_up),
        .link_up_o      (link_up),
        .link_down_cnt_o(down_cnt),
        .retrain_req_o  (retrain),
        .link_led_o     (led),
        .state_o        (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        int         fld;
        logic [7:0] val;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          errs = 0;
    int          edges_m = 0;
    logic [23:0] led_cnt_m;
    int          exp_cnt;

    function automatic logic [7:0] observed(input int fld);
        case (fld)
            0:       return {7'b0, link_up};
            1:       return down_cnt;
            2:       return {7'b0, retrain};
            3:       return {7'b0, led};
            default: return {6'b0, state};
        endcase
    endfunction

    task automatic push(input string tag, input int fld, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.fld = fld;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        logic [7:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observed(e.fld);
            vectors++;
            assert (o === e.val) else begin
                errs++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.val);
            end
        end
    endtask

    // LED expectation comes from the bench's own count of edges since reset release.
    task automatic expect_all(input string tag, input logic lu, input logic [7:0] cnt,
                              input logic rr, input logic [1:0] st);
        logic l;
        led_cnt_m = 24'(edges_m);
        l = (st == 2'b00) ? 1'b0 : (st == 2'b11) ? 1'b1 : led_cnt_m[2];
        push({tag, ".link_up"}, 0, {7'b0, lu});
        push({tag, ".cnt"},     1, cnt);
        push({tag, ".retrain"}, 2, {7'b0, rr});
        push({tag, ".led"},     3, {7'b0, l});
        push({tag, ".state"},   4, {6'b0, st});
        drain();
    endtask

    // okv: 0 = not ok (alternating which term fails), 1 = ok
    task automatic cyc(input logic env, input logic okv);
        en = env;
        if (okv) begin
            ltssm = 5'h0F;
            dl_up = 1'b1;
        end else if (edges_m % 2 == 0) begin
            ltssm = 5'h0F;
            dl_up = 1'b0;
        end else begin
            ltssm = 5'h07;
            dl_up = 1'b1;
        end
        @(posedge clk);
        #1;
        edges_m++;
    endtask

    task automatic go_up(input string tag, input logic [7:0] cnt);
        cyc(1'b1, 1'b1);
        expect_all({tag, ".stable"}, 1'b0, cnt, 1'b0, 2'b10);
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b1);
            expect_all({tag, ".deb"}, (k == 8), cnt, 1'b0, (k == 8) ? 2'b11 : 2'b10);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en = 1'b0;
        ltssm = 5'h00;
        dl_up = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b0;
        edges_m = 0;
    endtask

    initial begin
        do_reset();
        expect_all("reset", 1'b0, 8'h00, 1'b0, 2'b00);
        for (int i = 0; i < 100; i++) begin
            cyc(1'b0, 1'b0);
            expect_all("idle", 1'b0, 8'h00, 1'b0, 2'b00);
        end

        // Clean link-up: ok from the 5th TRAIN cycle
        cyc(1'b1, 1'b0);
        expect_all("enable", 1'b0, 8'h00, 1'b0, 2'b01);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0);
            expect_all("train", 1'b0, 8'h00, 1'b0, 2'b01);
        end
        go_up("clean", 8'h00);
        cyc(1'b1, 1'b1);
        expect_all("hold_up", 1'b1, 8'h00, 1'b0, 2'b11);

        // Disable from UP: no count, no pulse
        cyc(1'b0, 1'b0);
        expect_all("disable_up", 1'b0, 8'h00, 1'b0, 2'b00);

        // Glitch rejection
        cyc(1'b1, 1'b0);
        expect_all("g_enable", 1'b0, 8'h00, 1'b0, 2'b01);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b1);
            expect_all("g_high", 1'b0, 8'h00, 1'b0, 2'b10);
        end
        cyc(1'b1, 1'b0);
        expect_all("g_glitch", 1'b0, 8'h00, 1'b0, 2'b01);
        go_up("g_rise", 8'h00);

        // Training timeout
        cyc(1'b0, 1'b0);
        expect_all("t_idle", 1'b0, 8'h00, 1'b0, 2'b00);
        cyc(1'b1, 1'b0);
        expect_all("t_entry", 1'b0, 8'h00, 1'b0, 2'b01);
        for (int j = 1; j <= 100; j++) begin
            cyc(1'b1, 1'b0);
            expect_all("timeout", 1'b0, 8'h00, (j % 32 == 0), 2'b01);
        end

        // Drop counting and saturation
        for (int i = 1; i <= 300; i++) begin
            exp_cnt = (i - 1 > 255) ? 255 : i - 1;
            go_up("d_up", 8'(exp_cnt));
            cyc(1'b1, 1'b0);
            exp_cnt = (i > 255) ? 255 : i;
            expect_all("drop", 1'b0, 8'(exp_cnt), 1'b0, 2'b01);
        end
        go_up("d_final", 8'hFF);
        cyc(1'b0, 1'b0);
        expect_all("d_disable", 1'b0, 8'hFF, 1'b0, 2'b00);

        // Async reset while UP
        cyc(1'b1, 1'b0);
        expect_all("r_enable", 1'b0, 8'hFF, 1'b0, 2'b01);
        go_up("r_up", 8'hFF);
        #2;
        rst = 1'b1;
        #1;
        push("async_rst.link_up", 0, 8'h00);
        push("async_rst.cnt",     1, 8'h00);
        push("async_rst.state",   4, 8'h00);
        push("async_rst.led",     3, 8'h00);
        drain();
        #1;
        rst = 1'b0;
        edges_m = 0;
        en = 1'b0;
        cyc(1'b0, 1'b0);
        expect_all("post_rst", 1'b0, 8'h00, 1'b0, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule

// File: doc/pcie_link_mon.md
# pcie_link_mon

Monitors the PCIe hard core's training status downstream of the LTSSM-enable/heartbeat logic. It consumes the core's LTSSM state code and data-link-up flag and produces a debounced `link_up_o` for the SGDMA engine. It also provides a saturating link-drop counter, a one-cycle retrain request when training stalls, and a link LED pattern. All of it runs in the core clock domain.

## Interface
Parameters:
- `L0_CODE`, default 5'h0F: LTSSM state code meaning L0.
- `DEBOUNCE_CYC`, default 1024: cycles that L0 plus link-up must hold before `link_up_o` asserts; minimum 2.
- `TRAIN_TIMEOUT`, default 24'd10_000_000: cycles allowed in training before `retrain_req_o` pulses; minimum 2.
- `LED_BIT`, default 21: bit of the free-running 24-bit counter that drives the blink.

Ports:
- `core_clk`, in, 1: core clock; the block's only clock.
- `core_rst`, in, 1: asynchronous, active-high reset.
- `ltssm_enable_i`, in, 1: LTSSM enable, the same signal driven to the hard core.
- `ltssm_state_i`, in, 5: LTSSM state from the hard core, synchronous to `core_clk`.
- `dl_link_up_i`, in, 1: data-link-layer up, synchronous to `core_clk`.
- `link_up_o`, out, 1: debounced link up.
- `link_down_cnt_o`, out, 8: count of UP→TRAIN drops, saturating.
- `retrain_req_o`, out, 1: one-cycle pulse when a training timeout occurs.
- `link_led_o`, out, 1: link LED.
- `state_o`, out, 2: current FSM state, for debug.

## Operation
- Condition term: `ok` = `dl_link_up_i` && (`ltssm_state_i` == `L0_CODE`).
- FSM encoding: IDLE = 2'b00, TRAIN = 2'b01, STABLE = 2'b10, UP = 2'b11.
- Disable priority: in any state, `ltssm_enable_i` = 0 forces IDLE on the next edge.
  - The phase counter clears.
  - `link_down_cnt_o` does not change.
- IDLE → TRAIN when `ltssm_enable_i` = 1. The phase counter clears.
- TRAIN behaviour:
  - The phase counter increments every cycle.
  - `ok` = 1 → STABLE; the counter clears.
  - Otherwise, when the counter reaches `TRAIN_TIMEOUT`-1, `retrain_req_o` pulses for one cycle. The counter clears and the FSM stays in TRAIN.
  - If `ok` and the timeout coincide, `ok` wins and no pulse is generated.
- STABLE behaviour:
  - `ok` = 0 → TRAIN; the counter clears. This is not a drop, so `link_down_cnt_o` does not change.
  - `ok` = 1 and counter == `DEBOUNCE_CYC`-1 → UP.
  - Otherwise the counter increments.
- UP behaviour:
  - `ok` = 0 → TRAIN; the counter clears.
  - `link_down_cnt_o` increments, saturating at 8'hFF.
- Phase counter: 24 bits wide, shared between TRAIN and STABLE.
- Free-running 24-bit LED counter: increments every cycle and wraps naturally.
- `link_led_o` by state:
  - IDLE: 0.
  - TRAIN or STABLE: LED counter[`LED_BIT`].
  - UP: 1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Reset values:
  - State IDLE, both counters 0.
  - `link_up_o` = 0, `link_down_cnt_o` = 0, `retrain_req_o` = 0, `link_led_o` = 0, `state_o` = 2'b00.
- Reset mid-operation: asynchronous return to the reset values, including `link_down_cnt_o` (it is not retained).
- `link_up_o` is the registered value of (next state == UP). It updates on the same edge as the state register.
- Enable latency: `ltssm_enable_i` rising at edge E → `state_o` = TRAIN after E+1.
- Link-up latency: `ok` first sampled high in TRAIN at edge T, and held, gives:
  - `state_o` = STABLE after T+1.
  - `link_up_o` = 1 after T+1+`DEBOUNCE_CYC`.
- Link-down latency: `ok` low sampled at edge D in UP gives, after D+1:
  - `link_up_o` = 0.
  - `state_o` = TRAIN.
  - `link_down_cnt_o` incremented.
- Retrain: `retrain_req_o` is high for exactly one cycle every `TRAIN_TIMEOUT` cycles of continuous TRAIN. The first pulse comes `TRAIN_TIMEOUT` cycles after TRAIN entry.
- Disable in UP: `link_up_o` = 0 one cycle later; no count increment and no retrain pulse.

## Test plan
Bench parameters: `DEBOUNCE_CYC`=8, `TRAIN_TIMEOUT`=32, `LED_BIT`=2.
- Reset/idle: `core_rst` pulse, enable=0 → all outputs 0, `state_o`=00, LED stays 0 for 100 cycles.
- Clean link-up: enable=1, then `ok`=1 from the 5th TRAIN cycle and held → STABLE next cycle, `link_up_o`=1 exactly 9 cycles after `ok` was first sampled, LED solid 1.
- Glitch rejection: `ok` high 5 cycles, low 1, high again → FSM returns to TRAIN; `link_up_o` asserts only 9 cycles after the final rise; `link_down_cnt_o`=0.
- Training timeout: enable=1, `ok`=0 for 100 cycles → `retrain_req_o` pulses at TRAIN cycles 32, 64, 96 (each 1 cycle wide); LED toggles every 4 cycles.
- Drop counting/saturation: 300 UP→drop cycles → `link_down_cnt_o` reads 1, 2, … and holds at 255. A disable from UP leaves the count unchanged.
- Async reset in UP: `core_rst` asserted mid-cycle → `link_up_o` and `link_down_cnt_o` clear immediately, without waiting for a clock edge.
